spdif_encoder: RTL and testbench

// - S/PDIF (IEC 60958) transmitter, the transmit counterpart of the chip's S/PDIF-to-I2S receive path.
// - Accepts 24-bit stereo PCM pairs over a valid/ready handshake and builds 192-frame blocks (B/M/W preambles, V/U/C/P).
// - Emits a biphase-mark coded serial stream on one pin.

---
 rtl/spdif_encoder.sv | 172 +++++++++++++++++
 tb/tb_spdif_encoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/spdif_encoder.sv
// S/PDIF (IEC 60958) biphase-mark transmitter with 192-frame block framing.
// Define SPDIF_TX_CHSTAT_EN to insert channel-status bits from cs_word.
module spdif_encoder #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        enable,
    input  logic [23:0] sample_left,
    input  logic [23:0] sample_right,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic [31:0] cs_word,
    output logic        spdif_out,
    output logic        block_start,
    output logic        underrun
);
    localparam int UI_W = $clog2(CLK_DIV);

    localparam logic [7:0] PRE_B = 8'b11101000;
    localparam logic [7:0] PRE_M = 8'b11100010;
    localparam logic [7:0] PRE_W = 8'b11100100;

    logic [UI_W-1:0] ui_cnt;
    logic [5:0]      slot;
    logic            half;
    logic [7:0]      frame;
    logic            buf_full;
    logic [23:0]     buf_l;
    logic [23:0]     buf_r;
    logic [23:0]     aud_l;
    logic [23:0]     aud_r;
    logic            v_bit;
    logic            pre_lvl;

    logic            tick;
    logic            frame_start;
    logic            right;
    logic            pre_ui;
    logic [4:0]      sub_slot;
    logic [2:0]      pre_idx;
    logic [7:0]      pre_pat;
    logic [23:0]     aud;
    logic            c_bit;
    logic            p_bit;
    logic [31:0]     cells;
    logic            cell_bit;
    logic            nxt_out;

    assign sample_ready = ~buf_full;
    assign tick         = enable && (ui_cnt == UI_W'(CLK_DIV - 1));
    assign right        = slot[5];
    assign sub_slot     = slot[4:0];
    assign frame_start  = tick && (slot == 6'd0) && !half;
    assign pre_ui       = sub_slot < 5'd4;
    assign pre_idx      = {sub_slot[1:0], half};

`ifdef SPDIF_TX_CHSTAT_EN
    logic [31:0] cs_reg;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cs_reg <= '0;
        end else if (frame_start && frame == 8'd0) begin
            cs_reg <= cs_word;
        end
    end

    assign c_bit = (frame < 8'd32) ? cs_reg[frame[4:0]] : 1'b0;
`else
    logic unused_cs;
    assign unused_cs = ^cs_word;
    assign c_bit     = 1'b0;
`endif

    // Cell vector indexed by sub-slot: preamble slots 0-3 are don't-care.
    assign aud      = right ? aud_r : aud_l;
    assign p_bit    = ^{c_bit, v_bit, aud};
    assign cells    = {p_bit, c_bit, 1'b0, v_bit, aud, 4'b0000};
    assign cell_bit = cells[sub_slot];

    always_comb begin
        pre_pat = PRE_M;
        unique case (1'b1)
            right:                         pre_pat = PRE_W;
            !right && (frame == 8'd0):     pre_pat = PRE_B;
            !right && (frame != 8'd0):     pre_pat = PRE_M;
            default:                       pre_pat = PRE_M;
        endcase
    end

    always_comb begin
        nxt_out = spdif_out;
        unique case (1'b1)
            pre_ui && (pre_idx == 3'd0):
                nxt_out = pre_pat[7] ^ spdif_out;
            pre_ui && (pre_idx != 3'd0):
                nxt_out = pre_pat[3'd7 - pre_idx] ^ pre_lvl;
            !pre_ui && !half:
                nxt_out = ~spdif_out;
            !pre_ui && half:
                nxt_out = cell_bit ? ~spdif_out : spdif_out;
            default:
                nxt_out = spdif_out;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            ui_cnt      <= '0;
            slot        <= '0;
            half        <= 1'b0;
            frame       <= '0;
            buf_full    <= 1'b0;
            buf_l       <= '0;
            buf_r       <= '0;
            aud_l       <= '0;
            aud_r       <= '0;
            v_bit       <= 1'b0;
            pre_lvl     <= 1'b0;
            spdif_out   <= 1'b0;
            block_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            block_start <= 1'b0;
            underrun    <= 1'b0;
            if (sample_valid && sample_ready) begin
                buf_full <= 1'b1;
                buf_l    <= sample_left;
                buf_r    <= sample_right;
            end
            if (!enable) begin
                ui_cnt    <= '0;
                slot      <= '0;
                half      <= 1'b0;
                frame     <= '0;
                spdif_out <= 1'b0;
            end else begin
                ui_cnt <= tick ? '0 : ui_cnt + 1'b1;
                if (tick) begin
                    spdif_out <= nxt_out;
                    if (pre_ui && pre_idx == 3'd0) begin
                        pre_lvl <= spdif_out;
                    end
                    half <= ~half;
                    if (half) begin
                        slot <= slot + 6'd1;
                        if (slot == 6'd63) begin
                            frame <= (frame == 8'd191) ? 8'd0 : frame + 8'd1;
                        end
                    end
                end
                // Pair hand-off happens once per frame, at UI 0 of the left subframe.
                if (frame_start) begin
                    block_start <= (frame == 8'd0);
                    if (buf_full) begin
                        aud_l    <= buf_l;
                        aud_r    <= buf_r;
                        v_bit    <= 1'b0;
                        buf_full <= 1'b0;
                    end else begin
                        aud_l    <= '0;
                        aud_r    <= '0;
                        v_bit    <= 1'b1;
                        underrun <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spdif_encoder.sv
// Directed self-checking bench for spdif_encoder: captures the line per UI
// and biphase-decodes each subframe independently of the encoder.
module tb_spdif_encoder;
    localparam int CLK_DIV = 2;
    localparam int FRAME_CYC = 128 * CLK_DIV;
    localparam int BLOCK_CYC = 192 * FRAME_CYC;

    localparam logic [7:0] PB = 8'b11101000;
    localparam logic [7:0] PM = 8'b11100010;
    localparam logic [7:0] PW = 8'b11100100;

    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [23:0] sample_left = '0;
    logic [23:0] sample_right = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic [31:0] cs_word = 32'h0000_0004;
    logic        spdif_out;
    logic        block_start;
    logic        underrun;

    always #5 clk_in = ~clk_in;

    spdif_encoder #(.CLK_DIV(CLK_DIV)) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .enable       (enable),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .cs_word      (cs_word),
        .spdif_out    (spdif_out),
        .block_start  (block_start),
        .underrun     (underrun)
    );

    int n_checks = 0;
    int n_fail = 0;
    logic ui [0:127];

    int cyc = 0;
    int ur_count = 0;
    int ur_last = 0;
    int ur_gap = 0;
    int bs_count = 0;
    int bs_last = 0;
    int bs_gap = 0;

    always @(negedge clk_in) begin
        cyc = cyc + 1;
        if (underrun === 1'b1) begin
            if (ur_count > 0) ur_gap = cyc - ur_last;
            ur_last = cyc;
            ur_count = ur_count + 1;
        end
        if (block_start === 1'b1) begin
            if (bs_count > 0) bs_gap = cyc - bs_last;
            bs_last = cyc;
            bs_count = bs_count + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] mk(input logic [23:0] s,
                                       input logic v, input logic c);
        return {^{c, v, s}, c, 1'b0, v, s};
    endfunction

    function automatic logic exp_c(input int n);
`ifdef SPDIF_TX_CHSTAT_EN
        return (n % 192) == 2;
`else
        return 1'b0;
`endif
    endfunction

    task automatic next_ui(output logic v);
        repeat (CLK_DIV) @(posedge clk_in);
        #1;
        v = spdif_out;
    endtask

    task automatic cap_frame(output logic bs0, output logic ur0,
                             output logic rdy0);
        for (int i = 0; i < 128; i++) begin
            next_ui(ui[i]);
            if (i == 0) begin
                bs0 = block_start;
                ur0 = underrun;
                rdy0 = sample_ready;
            end
        end
    endtask

    task automatic decode(input int off, output logic [7:0] pre,
                          output logic [27:0] bits, output int bad);
        bad = 0;
        for (int i = 0; i < 8; i++) pre[7-i] = ui[off+i];
        for (int k = 4; k < 32; k++) begin
            if (ui[off+2*k] === ui[off+2*k-1]) bad++;
            bits[k-4] = ui[off+2*k] ^ ui[off+2*k+1];
        end
    endtask

    task automatic check_frame(input int n, input logic lvl,
                               input logic [23:0] sl, input logic [23:0] sr,
                               input logic v);
        logic [7:0]  pre;
        logic [27:0] bits;
        int          bad;
        logic [7:0]  lp;
        lp = ((n % 192) == 0) ? PB : PM;
        decode(0, pre, bits, bad);
        check($sformatf("f%0d_L_pre", n), 64'(pre), 64'(lp ^ {8{lvl}}));
        check($sformatf("f%0d_L_bits", n), 64'(bits), 64'(mk(sl, v, exp_c(n))));
        check($sformatf("f%0d_L_bmc", n), 64'(bad), 64'd0);
        decode(64, pre, bits, bad);
        check($sformatf("f%0d_R_pre", n), 64'(pre), 64'(PW ^ {8{ui[63]}}));
        check($sformatf("f%0d_R_bits", n), 64'(bits), 64'(mk(sr, v, exp_c(n))));
        check($sformatf("f%0d_R_bmc", n), 64'(bad), 64'd0);
    endtask

    initial begin
        logic bs0, ur0, rdy0, lvl, tmp;
        bit   found;

        repeat (3) @(posedge clk_in);
        #1;
        check("rst_out", 64'(spdif_out), 64'd0);
        check("rst_ready", 64'(sample_ready), 64'd1);
        check("rst_bs", 64'(block_start), 64'd0);
        check("rst_ur", 64'(underrun), 64'd0);

        reset = 1'b0;
        repeat (20) @(posedge clk_in);
        #1;
        check("idle_out", 64'(spdif_out), 64'd0);

        sample_left = 24'h000001;
        sample_right = 24'h800000;
        sample_valid = 1'b1;
        @(posedge clk_in);
        #1;
        sample_valid = 1'b0;
        check("push_ready", 64'(sample_ready), 64'd0);

        enable = 1'b1;
        cap_frame(bs0, ur0, rdy0);
        check("f0_bs", 64'(bs0), 64'd1);
        check("f0_ur", 64'(ur0), 64'd0);
        check("f0_ready", 64'(rdy0), 64'd1);
        check_frame(0, 1'b0, 24'h000001, 24'h800000, 1'b0);
        lvl = ui[127];

        for (int n = 1; n <= 192; n++) begin
            cap_frame(bs0, ur0, rdy0);
            check($sformatf("f%0d_ur", n), 64'(ur0), 64'd1);
            check($sformatf("f%0d_bs", n), 64'(bs0), 64'(n == 192));
            check_frame(n, lvl, 24'h0, 24'h0, 1'b1);
            lvl = ui[127];
            if (n == 3) begin
                check("ur_count", 64'(ur_count), 64'd3);
                check("ur_gap", 64'(ur_gap), 64'(FRAME_CYC));
            end
        end
        check("bs_count", 64'(bs_count), 64'd2);
        check("bs_gap", 64'(bs_gap), 64'(BLOCK_CYC));

        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            next_ui(tmp);
            found = (tmp === 1'b1);
        end
        check("find_high", 64'(found), 64'd1);
        enable = 1'b0;
        @(posedge clk_in);
        #1;
        check("dis_out", 64'(spdif_out), 64'd0);

        sample_left = 24'h123456;
        sample_right = 24'hFEDCBA;
        sample_valid = 1'b1;
        @(posedge clk_in);
        #1;
        sample_valid = 1'b0;
        repeat (10) @(posedge clk_in);
        #1;
        check("dis_hold", 64'(sample_ready), 64'd0);

        enable = 1'b1;
        cap_frame(bs0, ur0, rdy0);
        check("re_bs", 64'(bs0), 64'd1);
        check("re_ur", 64'(ur0), 64'd0);
        check("re_ready", 64'(rdy0), 64'd1);
        check_frame(0, 1'b0, 24'h123456, 24'hFEDCBA, 1'b0);

        sample_valid = 1'b1;
        @(posedge clk_in);
        #1;
        sample_valid = 1'b0;
        check("mid_full", 64'(sample_ready), 64'd0);
        for (int i = 0; i < 5; i++) next_ui(tmp);
        reset = 1'b1;
        #1;
        check("mid_rst_out", 64'(spdif_out), 64'd0);
        check("mid_rst_ready", 64'(sample_ready), 64'd1);
        check("mid_rst_bs", 64'(block_start), 64'd0);
        check("mid_rst_ur", 64'(underrun), 64'd0);
        @(posedge clk_in);
        #1;
        reset = 1'b0;
        next_ui(tmp);
        check("post_rst_ur", 64'(underrun), 64'd1);
        check("post_rst_bs", 64'(block_start), 64'd1);
        check("post_rst_ui0", 64'(tmp), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
